// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, pipeline stage record and lane/alignment helpers for dmem_lsu
package dmem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef struct packed {
    logic        err;
    logic        we;
    logic [1:0]  size;
    logic [1:0]  off;
    logic        uns;
    logic [31:0] word;
  } stage_t;
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_B ? 4'b0001 << off :
           size == SZ_H ? (off[1] ? 4'b1100 : 4'b0011) :
           size == SZ_W ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == 2'b11 || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_load_fmt.sv
// dmem_load_fmt: selects the addressed byte/half of a loaded word and sign- or zero-extends it
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata
);
  logic [15:0] sh;
  always_comb begin
    sh = 16'(rdata_word >> {off, 3'b000});
    rdata = size == SZ_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
            size == SZ_H ? {{16{~uns & sh[15]}}, sh[15:0]} : rdata_word;
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed data memory with sub-word access, RD_LAT-deep response pipeline and backpressure
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0]   mem [DEPTH];
  stage_t            pl [RD_LAT];
  logic [RD_LAT-1:0] v;
  logic [AW-1:0]     idx;
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [XLEN-1:0]   wrep, fmt;
  logic              stall, accept, err, unused_addr;
  assign idx         = req_addr[AW+1:2];
  assign off         = req_addr[1:0];
  assign unused_addr = ^req_addr[ADDR_W-1:AW+2];
  assign stall       = rsp_valid && !rsp_ready;
  assign req_ready   = !stall;
  assign accept      = req_valid && req_ready;
  assign err         = misaligned(req_size, off);
  assign mask        = lane_mask(req_size, off);
  assign wrep        = req_size == SZ_B ? {4{req_wdata[7:0]}} :
                       req_size == SZ_H ? {2{req_wdata[15:0]}} : req_wdata;
  always_ff @(posedge clk)
    if (accept && req_we && !err)
      for (int b = 0; b < 4; b++)
        if (mask[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
  // payload carries no reset; only the valid chain below decides what is live
  always_ff @(posedge clk)
    if (!stall) begin
      pl[0] <= {err, req_we, req_size, off, req_unsigned, mem[idx]};
      for (int i = 1; i < RD_LAT; i++) pl[i] <= pl[i-1];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else if (!stall) begin
      v[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) v[i] <= v[i-1];
    end
  dmem_load_fmt u_fmt (
    .rdata_word(pl[RD_LAT-1].word),
    .off       (pl[RD_LAT-1].off),
    .size      (pl[RD_LAT-1].size),
    .uns       (pl[RD_LAT-1].uns),
    .rdata     (fmt)
  );
  assign rsp_valid = v[RD_LAT-1];
  assign rsp_err   = rsp_valid && pl[RD_LAT-1].err;
  assign rsp_rdata = rsp_valid && !pl[RD_LAT-1].err && !pl[RD_LAT-1].we ? fmt : '0;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench driving three dmem_lsu instances (RD_LAT 1, 2, 4) in lockstep
module tb_dmem_lsu;
  localparam int LAT [3] = '{1, 2, 4};
  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
    bit          chk;
  } exp_t;
  logic        clk = 0, rst_n = 0, req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic [2:0]  rdy, rv, re;
  logic [31:0] rd [3];
  logic        all_rdy, vin;
  exp_t        q [3][$];
  int          cyc = 0, n_cmp = 0, n_bad = 0;
  bit          lat_chk = 1;
  bit   [2:0]  hold = '0;
  logic [32:0] hval [3];
  assign all_rdy = &rdy;
  assign vin     = req_valid && all_rdy;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  dmem_lsu #(.RD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vin), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(re[0]));
  dmem_lsu #(.RD_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(vin), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(re[1]));
  dmem_lsu #(.RD_LAT(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(vin), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rv[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_err(re[2]));
  task automatic cmp(input string nm, input int k, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (RD_LAT=%0d): got %h, expected %h", nm, LAT[k], act, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) hold = '0;
    else for (int k = 0; k < 3; k++) begin
      if (hold[k]) begin
        cmp("stall_valid", k, 33'(rv[k]), 33'd1);
        cmp("stall_data", k, {re[k], rd[k]}, hval[k]);
      end
      hold[k] = rv[k] && !rsp_ready;
      hval[k] = {re[k], rd[k]};
      if (rv[k] && rsp_ready) begin
        if (q[k].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp (RD_LAT=%0d): got %h, expected no response", LAT[k], rd[k]);
        end else begin
          e = q[k].pop_front();
          cmp("rdata", k, {1'b0, rd[k]}, {1'b0, e.rd});
          cmp("err", k, 33'(re[k]), 33'(e.err));
          if (e.chk) cmp("latency", k, 33'(cyc + 1 - e.acc), 33'(LAT[k]));
        end
      end
    end
  end
  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int b = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata; req_valid = 1;
    #1;
    while (!all_rdy) begin
      if (++b > 100) begin
        $display("FAIL ready_timeout: req_ready stuck at %b, expected 111", rdy);
        $fatal(1);
      end
      @(negedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++) q[k].push_back('{exp_rd, exp_err, cyc + 1, lat_chk});
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  task automatic drain();
    int b = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && b < 60) begin
      @(negedge clk);
      b++;
    end
    for (int k = 0; k < 3; k++) cmp("drain", k, 33'(q[k].size()), 33'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cmp("reset_valid", k, 33'(rv[k]), 33'd0);
      cmp("reset_rsp", k, {re[k], rd[k]}, 33'd0);
      cmp("reset_ready", k, 33'(rdy[k]), 33'd1);
    end
    rst_n = 1;
    send(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0);
    send(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0);
    send(1, 32'h11, 2'b00, 0, 32'h00000055, 32'h0, 0);
    send(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD55EF, 0);
    send(0, 32'h13, 2'b00, 0, 32'h0, 32'hFFFFFFDE, 0);
    send(0, 32'h13, 2'b00, 1, 32'h0, 32'h000000DE, 0);
    send(0, 32'h12, 2'b01, 0, 32'h0, 32'hFFFFDEAD, 0);
    send(0, 32'h12, 2'b01, 1, 32'h0, 32'h0000DEAD, 0);
    send(0, 32'h13, 2'b01, 0, 32'h0, 32'h0, 1);
    send(1, 32'h12, 2'b10, 0, 32'h1, 32'h0, 1);
    send(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD55EF, 0);
    send(0, 32'h10, 2'b11, 0, 32'h0, 32'h0, 1);
    send(0, 32'h10, 2'b01, 0, 32'h0, 32'h000055EF, 0);
    send(0, 32'h11, 2'b00, 0, 32'h0, 32'h00000055, 0);
    send(1, 32'h400, 2'b10, 0, 32'hA5A5A5A5, 32'h0, 0);
    send(0, 32'h0, 2'b10, 0, 32'h0, 32'hA5A5A5A5, 0);
    send(1, 32'h2, 2'b01, 0, 32'hFFFF1234, 32'h0, 0);
    send(0, 32'h0, 2'b10, 0, 32'h0, 32'h1234A5A5, 0);
    send(1, 32'h20, 2'b10, 0, 32'h80FF7F01, 32'h0, 0);
    send(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD55EF, 0);
    send(0, 32'h0, 2'b10, 0, 32'h0, 32'h1234A5A5, 0);
    send(0, 32'h20, 2'b00, 0, 32'h0, 32'h00000001, 0);
    send(0, 32'h21, 2'b00, 0, 32'h0, 32'h0000007F, 0);
    send(0, 32'h22, 2'b00, 0, 32'h0, 32'hFFFFFFFF, 0);
    send(0, 32'h22, 2'b00, 1, 32'h0, 32'h000000FF, 0);
    send(0, 32'h22, 2'b01, 0, 32'h0, 32'hFFFF80FF, 0);
    send(0, 32'h22, 2'b01, 1, 32'h0, 32'h000080FF, 0);
    drain();
    lat_chk = 0;
    fork
      begin
        send(0, 32'h420, 2'b10, 0, 32'h0, 32'h80FF7F01, 0);
        send(0, 32'h20, 2'b01, 0, 32'h0, 32'h00007F01, 0);
        send(0, 32'h23, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0);
        send(0, 32'h11, 2'b00, 1, 32'h0, 32'h00000055, 0);
        send(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD55EF, 0);
        send(0, 32'h10, 2'b01, 1, 32'h0, 32'h000055EF, 0);
        send(0, 32'h10, 2'b00, 0, 32'h0, 32'hFFFFFFEF, 0);
        send(0, 32'h0, 2'b10, 0, 32'h0, 32'h1234A5A5, 0);
      end
      begin
        repeat (5) @(posedge clk);
        #2 rsp_ready = 0;
        #1 for (int k = 0; k < 3; k++) cmp("stall_ready", k, 33'(rdy[k]), 33'(!rv[k]));
        repeat (3) @(posedge clk);
        #2 rsp_ready = 1;
      end
    join
    drain();
    lat_chk = 1;
    send(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD55EF, 0);
    send(0, 32'h0, 2'b10, 0, 32'h0, 32'h1234A5A5, 0);
    #2 rst_n = 0;
    #1 for (int k = 0; k < 3; k++) begin
      cmp("flush_valid", k, 33'(rv[k]), 33'd0);
      q[k].delete();
    end
    @(negedge clk);
    #2 rst_n = 1;
    #1 for (int k = 0; k < 3; k++) cmp("post_reset_ready", k, 33'(rdy[k]), 33'd1);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++) cmp("no_stale_rsp", k, 33'(rv[k]), 33'd0);
    send(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD55EF, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
